// File: rtl/id_pkg.sv
// Shared RV32I decode definitions for the ID stage: opcodes, immediate formats,
// the ID/EX packet layout and the immediate generator.
package id_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd6
    } imm_fmt_e;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        is_load;
    } id_ex_t;

    function automatic imm_fmt_e fmt_of(input logic [6:0] opc);
        imm_fmt_e f;
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: f = FMT_I;
            OPC_STORE:                      f = FMT_S;
            OPC_BRANCH:                     f = FMT_B;
            OPC_LUI, OPC_AUIPC:             f = FMT_U;
            OPC_JAL:                        f = FMT_J;
            OPC_OP:                         f = FMT_R;
            default:                        f = FMT_NONE;
        endcase
        return f;
    endfunction

    // R-type and unknown opcodes carry no immediate.
    function automatic logic [31:0] imm_gen(input logic [31:0] inst, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm = {inst[31:12], 12'h000};
            FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = 32'h0000_0000;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Architectural register file: two combinational read ports, one write port.
// Define ID_WB_BYPASS_EN to forward a same-cycle write to the read ports.
module id_regfile
    import id_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      rs1_idx,
    input  logic [4:0]      rs2_idx,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            we,
    input  logic [AW-1:0]   wr,
    input  logic [XLEN-1:0] wd
);

`ifdef ID_WB_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    // x0 has no storage, so it reads zero and swallows writes by construction.
    logic [XLEN-1:0] mem_r [1:NREG-1];

    // Storage update; indices outside 1..NREG-1 never match and are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (we && (wr == AW'(i))) begin
                    mem_r[i] <= wd;
                end
            end
        end
    end

    // Read mux: unmatched indices (0 and >= NREG) fall through to zero.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        for (int i = 1; i < NREG; i++) begin
            rs1_data = (rs1_idx == 5'(i))
                     ? ((BYPASS && we && (wr == AW'(i))) ? wd : mem_r[i])
                     : rs1_data;
            rs2_data = (rs2_idx == 5'(i))
                     ? ((BYPASS && we && (wr == AW'(i))) ? wd : mem_r[i])
                     : rs2_data;
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// RV32I decode stage with ID/EX register, valid/ready flow control and load-use bubble.
// Define ID_WB_BYPASS_EN to let operand reads see the same-cycle write-back.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_inst,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [AW-1:0]   ex_rd,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_func3,
    output logic [6:0]      ex_func7,
    output logic            ex_is_load
);

    imm_fmt_e        fmt_s;
    logic [31:0]     imm_s;
    logic            rs1_used_s;
    logic            rs2_used_s;
    logic            stall_s;
    logic            accept_s;
    logic [XLEN-1:0] rs1_rd_s;
    logic [XLEN-1:0] rs2_rd_s;

    id_ex_t          pkt_r;
    logic            ex_valid_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] rs1_r;
    logic [XLEN-1:0] rs2_r;

    id_regfile #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_idx  (if_inst[19:15]),
        .rs2_idx  (if_inst[24:20]),
        .rs1_data (rs1_rd_s),
        .rs2_data (rs2_rd_s),
        .we       (wb_en),
        .wr       (wb_rd),
        .wd       (wb_data)
    );

    // Decode of the offered instruction: format, immediate and which sources it reads.
    always_comb begin
        fmt_s      = fmt_of(if_inst[6:0]);
        imm_s      = imm_gen(if_inst, fmt_s);
        rs1_used_s = (fmt_s != FMT_U) && (fmt_s != FMT_J);
        rs2_used_s = (fmt_s == FMT_R) || (fmt_s == FMT_S) || (fmt_s == FMT_B);
    end

    // A load leaving for EX this cycle cannot feed a dependent accepted now; the
    // refusal lets the load drain, so the next cycle shows exactly one bubble.
    always_comb begin
        stall_s  = ex_valid_r && ex_ready && pkt_r.is_load && (pkt_r.rd != 5'd0) && if_valid
                && ((rs1_used_s && (if_inst[19:15] == pkt_r.rd))
                 || (rs2_used_s && (if_inst[24:20] == pkt_r.rd)));
        if_ready = rst_n && !stall_s && (!ex_valid_r || ex_ready);
        accept_s = if_valid && if_ready;
    end

    // ID/EX register: reset > flush > capture > drain; a held packet is never refreshed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_r <= 1'b0;
            pkt_r      <= '0;
            pc_r       <= '0;
            rs1_r      <= '0;
            rs2_r      <= '0;
        end else if (flush) begin
            ex_valid_r <= 1'b0;
        end else if (accept_s) begin
            ex_valid_r    <= 1'b1;
            pkt_r.opcode  <= if_inst[6:0];
            pkt_r.func3   <= if_inst[14:12];
            pkt_r.func7   <= if_inst[31:25];
            pkt_r.rd      <= if_inst[11:7];
            pkt_r.imm     <= imm_s;
            pkt_r.is_load <= (if_inst[6:0] == OPC_LOAD);
            pc_r          <= if_pc;
            rs1_r         <= rs1_rd_s;
            rs2_r         <= rs2_rd_s;
        end else if (ex_ready) begin
            ex_valid_r <= 1'b0;
        end
    end

    assign ex_valid    = ex_valid_r;
    assign ex_pc       = pc_r;
    assign ex_rs1_data = rs1_r;
    assign ex_rs2_data = rs2_r;
    assign ex_imm      = XLEN'(signed'(pkt_r.imm));
    assign ex_rd       = pkt_r.rd[AW-1:0];
    assign ex_opcode   = pkt_r.opcode;
    assign ex_func3    = pkt_r.func3;
    assign ex_func7    = pkt_r.func7;
    assign ex_is_load  = pkt_r.is_load;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: directed test-plan cases followed by random traffic.
module tb_id_stage_pipe;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    localparam logic [6:0] O_LOAD = 7'b0000011, O_OPIMM = 7'b0010011, O_JALR = 7'b1100111;
    localparam logic [6:0] O_STORE = 7'b0100011, O_BRANCH = 7'b1100011, O_LUI = 7'b0110111;
    localparam logic [6:0] O_AUIPC = 7'b0010111, O_JAL = 7'b1101111, O_OP = 7'b0110011;
    localparam logic [6:0] O_FENCE = 7'b0001111;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            if_valid = 1'b0;
    logic            if_ready;
    logic [31:0]     if_inst = 32'd0;
    logic [XLEN-1:0] if_pc = 32'd0;
    logic            flush = 1'b0;
    logic            wb_en = 1'b0;
    logic [AW-1:0]   wb_rd = 5'd0;
    logic [XLEN-1:0] wb_data = 32'd0;
    logic            ex_valid;
    logic            ex_ready = 1'b0;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [AW-1:0]   ex_rd;
    logic [6:0]      ex_opcode, ex_func7;
    logic [2:0]      ex_func3;
    logic            ex_is_load;

    typedef struct {
        logic [31:0] pc, rs1, rs2, imm;
        logic [4:0]  rd;
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        logic        ld;
    } pkt_t;

    pkt_t        q[$];
    logic [31:0] rf [32];
    logic [6:0]  ops [10] = '{O_LOAD, O_OPIMM, O_JALR, O_STORE, O_BRANCH,
                              O_LUI, O_AUIPC, O_JAL, O_OP, O_FENCE};
    int          checks = 0;
    int          errors = 0;
    logic        exp_valid = 1'b0;
    logic        mon_en = 1'b0;
    logic [31:0] pc_ctr = 32'h0000_1000;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
        .if_inst(if_inst), .if_pc(if_pc), .flush(flush), .wb_en(wb_en),
        .wb_rd(wb_rd), .wb_data(wb_data), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_func3(ex_func3),
        .ex_func7(ex_func7), .ex_is_load(ex_is_load)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference immediate: the offset each format denotes, as a signed number.
    function automatic logic [31:0] m_imm(input logic [31:0] i);
        case (i[6:0])
            O_LOAD, O_OPIMM, O_JALR: return 32'(signed'(i[31:20]));
            O_STORE:  return 32'(signed'({i[31:25], i[11:7]}));
            O_BRANCH: return 32'(signed'({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            O_LUI, O_AUIPC: return {i[31:12], 12'h000};
            O_JAL:    return 32'(signed'({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op == O_LUI || op == O_AUIPC || op == O_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == O_OP || op == O_STORE || op == O_BRANCH);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx, input logic we,
                                           input logic [4:0] wr, input logic [31:0] wd);
        if (idx == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
        if (we && wr == idx) return wd;
`endif
        return rf[idx];
    endfunction

    function automatic logic [31:0] mk_r(input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] rd);
        return {7'b0000000, rs2, rs1, 3'b000, rd, O_OP};
    endfunction

    function automatic logic [31:0] mk_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    // One clock cycle: drive inputs, check if_ready, then apply the edge to the model.
    task automatic step(input logic rst, input logic iv, input logic [31:0] inst, input logic er,
                        input logic fl, input logic we, input logic [4:0] wr, input logic [31:0] wd);
        pkt_t p;
        logic haz, rdy;
        @(negedge clk);
        rst_n = rst; if_valid = iv; if_inst = inst; if_pc = pc_ctr; ex_ready = er;
        flush = fl; wb_en = we; wb_rd = wr; wb_data = wd;
        #1;
        mon_en = 1'b1;
        exp_valid = (q.size() != 0);
        haz = 1'b0;
        if (exp_valid && er && iv && q[0].ld && q[0].rd != 5'd0)
            haz = (uses_rs1(inst[6:0]) && inst[19:15] == q[0].rd)
               || (uses_rs2(inst[6:0]) && inst[24:20] == q[0].rd);
        rdy = rst && !haz && (!exp_valid || er);
        chk("if_ready", 32'(if_ready), 32'(rdy));
        if (!rst) begin
            q.delete();
            for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        end else begin
            if (fl) begin
                q.delete();
            end else if (iv && rdy) begin
                p.pc = pc_ctr; p.imm = m_imm(inst); p.rd = inst[11:7];
                p.opc = inst[6:0]; p.f3 = inst[14:12]; p.f7 = inst[31:25];
                p.ld = (inst[6:0] == O_LOAD);
                p.rs1 = m_read(inst[19:15], we, wr, wd);
                p.rs2 = m_read(inst[24:20], we, wr, wd);
                q.push_back(p);
                pc_ctr = pc_ctr + 32'd4;
            end
            if (we && wr != 5'd0) rf[wr] = wd;
        end
    endtask

    // Monitor: compares the presented packet with the scoreboard head, pops on consumption.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                chk("ex_valid", 32'(ex_valid), 32'(exp_valid));
                if (exp_valid && rst_n && !flush && q.size() != 0) begin
                    chk("ex_pc", ex_pc, q[0].pc);
                    chk("ex_rs1_data", ex_rs1_data, q[0].rs1);
                    chk("ex_rs2_data", ex_rs2_data, q[0].rs2);
                    chk("ex_imm", ex_imm, q[0].imm);
                    chk("ex_rd", 32'(ex_rd), 32'(q[0].rd));
                    chk("ex_opcode", 32'(ex_opcode), 32'(q[0].opc));
                    chk("ex_func3", 32'(ex_func3), 32'(q[0].f3));
                    chk("ex_func7", 32'(ex_func7), 32'(q[0].f7));
                    chk("ex_is_load", 32'(ex_is_load), 32'(q[0].ld));
                    if (ex_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [31:0] inst;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;

        step(1'b0, 1'b1, 32'hFFF0_0293, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("reset_pc", ex_pc, 32'd0);
        chk("reset_imm", ex_imm, 32'd0);
        chk("reset_rs1", ex_rs1_data, 32'd0);
        chk("reset_rd", 32'(ex_rd), 32'd0);
        chk("reset_opcode", 32'(ex_opcode), 32'd0);

        // ADDI x5,x0,-1
        step(1'b1, 1'b1, 32'hFFF0_0293, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        // x3 write, x0 write ignored, then ADD x1,x3,x3 and a read of x0
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h1234_5678);
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd0, 32'h0000_DEAD);
        step(1'b1, 1'b1, mk_r(5'd3, 5'd3, 5'd1), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, 1'b1, mk_r(5'd0, 5'd0, 5'd8), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        // LW x6,0(x2) then dependent ADD x7,x6,x1: offered until accepted
        step(1'b1, 1'b1, mk_i(12'd0, 5'd2, 3'b010, 5'd6, O_LOAD), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, 1'b1, mk_r(5'd1, 5'd6, 5'd7), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, 1'b1, mk_r(5'd1, 5'd6, 5'd7), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        // Load to x0 causes no bubble
        step(1'b1, 1'b1, mk_i(12'd4, 5'd2, 3'b010, 5'd0, O_LOAD), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, 1'b1, mk_r(5'd1, 5'd0, 5'd7), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        // Back-pressure for three cycles, then release accepts the waiting instruction
        step(1'b1, 1'b1, mk_i(12'h7FF, 5'd3, 3'b000, 5'd9, O_OPIMM), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        for (int k = 0; k < 3; k++)
            step(1'b1, 1'b1, mk_r(5'd3, 5'd1, 5'd10), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, 1'b1, mk_r(5'd3, 5'd1, 5'd10), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        // Flush while holding with an offer; write-back in the same cycle still commits
        step(1'b1, 1'b1, mk_i(12'h800, 5'd1, 3'b000, 5'd11, O_OPIMM), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, 1'b1, mk_r(5'd1, 5'd1, 5'd12), 1'b0, 1'b1, 1'b1, 5'd4, 32'h0BAD_F00D);
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        // Same-cycle write of x4 with an instruction reading x4
        step(1'b1, 1'b1, mk_r(5'd4, 5'd4, 5'd13), 1'b1, 1'b0, 1'b1, 5'd4, 32'hA5A5_A5A5);
        step(1'b1, 1'b1, mk_r(5'd4, 5'd4, 5'd14), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            inst = $urandom();
            inst[6:0]   = ops[$urandom_range(0, 9)];
            inst[11:7]  = 5'($urandom_range(0, 7));
            inst[19:15] = 5'($urandom_range(0, 7));
            inst[24:20] = 5'($urandom_range(0, 7));
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), inst,
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom());
        end
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
